// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, reads a combinational imem,
// buffers fetched words in a small prefetch FIFO and hands {pc, instr, fault}
// to decode over a valid/ready handshake. Redirects flush and restart fetch;
// misaligned or out-of-range fetches produce a sticky fault entry.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 1000001,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_fault
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  // Fetch is legal while pc+4 stays within the array; 33 bits so pc+4 cannot wrap.
  localparam logic [32:0] PC_LIMIT = 33'(IMEM_BYTES);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [31:0]      fetch_pc;
  logic [31:0]      pc_mem    [FIFO_DEPTH];
  logic [31:0]      instr_mem [FIFO_DEPTH];
  logic             fault_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic        head_valid;
  logic        head_fault;
  logic        pop;
  logic        fetch_ok;
  logic        issue_ok;
  logic        push;
  logic        push_fault;
  logic        pc_advance;
  logic [31:0] push_instr;

  // imem is addressed straight from the fetch PC register
  assign imem_addr = fetch_pc;

  // FIFO head status and the consumer handshake; a fault head never pops
  always_comb begin
    head_valid = (count != '0);
    head_fault = head_valid && fault_mem[rd_ptr];
    pop        = head_valid && out_ready && !head_fault;
  end

  // Decode-side view of the FIFO head, forced to zero when empty
  always_comb begin
    out_valid = head_valid;
    out_pc    = '0;
    out_instr = '0;
    out_fault = 1'b0;
    if (head_valid) begin
      out_pc    = pc_mem[rd_ptr];
      out_instr = instr_mem[rd_ptr];
      out_fault = fault_mem[rd_ptr];
    end
  end

  // Legality of the current fetch address
  always_comb begin
    fetch_ok = (fetch_pc[1:0] == 2'b00) &&
               (({1'b0, fetch_pc} + 33'd4) <= PC_LIMIT);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: redirect always restarts, an illegal issue parks in FAULT
  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      state_next = ST_RUN;
    end else if (push_fault) begin
      state_next = ST_FAULT;
    end
  end

  // FSM outputs: issue gating; a slot frees up in the same cycle as a pop
  always_comb begin
    issue_ok   = 1'b0;
    push       = 1'b0;
    push_fault = 1'b0;
    pc_advance = 1'b0;
    push_instr = '0;
    if (state == ST_RUN) begin
      issue_ok = (count < CNT_FULL) || pop;
    end
    push       = issue_ok && !redirect_valid;
    push_fault = push && !fetch_ok;
    pc_advance = push && fetch_ok;
    if (pc_advance) begin
      push_instr = imem_data;
    end
  end

  // Fetch PC: redirect load, sequential advance, hold on fault
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
    end else if (pc_advance) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // FIFO storage; cleared on reset so no stale data can ever reach the head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
        fault_mem[i] <= 1'b0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= push_instr;
      fault_mem[wr_ptr] <= push_fault;
    end
  end

  // FIFO pointers and occupancy; a redirect discards everything, including a same-cycle pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed scenarios plus a randomized phase, all
// checked every cycle against a queue-based model of the fetch stream.
module tb_ifetch_ctrl;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int unsigned IMEM_BYTES = 1000001;
  localparam int unsigned FIFO_DEPTH = 2;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          fault;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc;
  bit          mstuck;

  ifetch_ctrl #(
    .RESET_PC   (RESET_PC),
    .IMEM_BYTES (IMEM_BYTES),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_fault      (out_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction memory: every address maps to a distinct word
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
  endfunction

  assign imem_data = imem_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc    = RESET_PC;
    mstuck = 0;
  endtask

  // One clock edge of the fetch stream, from the handshake and fetch rules
  task automatic model_edge(input bit rv, input logic [31:0] rpc, input bit rdy);
    bit   has_head;
    bit   do_pop;
    bit   can_issue;
    ent_t e;
    has_head  = (mq.size() > 0);
    do_pop    = has_head && rdy && !mq[0].fault;
    can_issue = !mstuck && ((mq.size() < FIFO_DEPTH) || do_pop);
    if (rv) begin
      mq.delete();
      mpc    = rpc;
      mstuck = 0;
      return;
    end
    if (do_pop) void'(mq.pop_front());
    if (can_issue) begin
      e.pc = mpc;
      if ((mpc % 4 == 0) && (longint'(mpc) + 4 <= longint'(IMEM_BYTES))) begin
        e.instr = imem_word(mpc);
        e.fault = 0;
        mpc     = mpc + 32'd4;
      end else begin
        e.instr = 32'h0;
        e.fault = 1;
        mstuck  = 1;
      end
      mq.push_back(e);
    end
  endtask

  task automatic check_all();
    ent_t h;
    h = '{pc: 32'h0, instr: 32'h0, fault: 0};
    if (mq.size() > 0) h = mq[0];
    check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    check("out_pc",    out_pc,         h.pc);
    check("out_instr", out_instr,      h.instr);
    check("out_fault", 32'(out_fault), 32'(h.fault));
    check("imem_addr", imem_addr,      mpc);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check just after
  task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(posedge clk);
    model_edge(rv, rpc, rdy);
    #1;
    check_all();
  endtask

  initial begin
    int          r;
    logic [31:0] rpc;

    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    #1;
    check_all();

    // Streaming with out_ready high: one instruction per cycle
    for (int i = 0; i < 4; i++) begin
      step(0, 32'h0, 1);
      check("stream_pc", out_pc, 32'(4 * i));
      check("stream_instr", out_instr, imem_word(32'(4 * i)));
    end

    // Back-pressure: FIFO fills at two entries, fetch stalls at pc 8
    step(1, 32'h0, 0);
    for (int i = 0; i < 5; i++) step(0, 32'h0, 0);
    check("bp_addr", imem_addr, 32'h8);
    check("bp_head", out_pc, 32'h0);
    step(0, 32'h0, 1);
    check("bp_rel0", out_pc, 32'h4);
    step(0, 32'h0, 1);
    check("bp_rel1", out_pc, 32'h8);

    // Redirect while full with a same-cycle pop
    step(0, 32'h0, 0);
    step(0, 32'h0, 0);
    step(1, 32'h100, 1);
    check("redir_bubble", 32'(out_valid), 32'h0);
    step(0, 32'h0, 1);
    check("redir_pc0", out_pc, 32'h100);
    step(0, 32'h0, 1);
    check("redir_pc1", out_pc, 32'h104);

    // Misaligned redirect: sticky fault head, ignored out_ready, then recovery
    step(1, 32'h102, 1);
    step(0, 32'h0, 1);
    for (int i = 0; i < 10; i++) step(0, 32'h0, 1);
    check("mis_fault", 32'(out_fault), 32'h1);
    check("mis_pc", out_pc, 32'h102);
    check("mis_instr", out_instr, 32'h0);
    step(1, 32'h0, 1);
    step(0, 32'h0, 1);
    check("mis_recover", out_pc, 32'h0);

    // End of imem: 999996 is the last legal word, 1000000 faults
    step(1, 32'd999988, 1);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 1);
    check("end_last", out_pc, 32'd999996);
    check("end_last_ok", 32'(out_fault), 32'h0);
    step(0, 32'h0, 1);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 1);
    check("end_fault_pc", out_pc, 32'd1000000);
    check("end_fault", 32'(out_fault), 32'h1);
    check("end_addr", imem_addr, 32'd1000000);
    step(1, 32'h0, 1);

    // Randomized traffic with occasional redirects of every kind
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 6) begin
        case ($urandom_range(0, 3))
          0:       rpc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
          1:       rpc = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
          2:       rpc = 32'd999960 + 32'($urandom_range(0, 48));
          default: rpc = $urandom;
        endcase
        step(1, rpc, ($urandom_range(0, 1) == 1));
      end else begin
        step(0, 32'h0, ($urandom_range(0, 9) < 7));
      end
    end

    // Asynchronous reset mid-stream with two entries queued
    step(1, 32'h40, 0);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 0);
    check("pre_rst_valid", 32'(out_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    check("rst_async_pc", out_pc, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();
    step(0, 32'h0, 1);
    check("rst_restart", out_pc, RESET_PC);
    step(0, 32'h0, 1);
    check("rst_next", out_pc, RESET_PC + 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
Instruction-fetch sequencer for the byte-addressable, combinational-read instruction memory (imem). It owns the fetch PC, drives imem_addr, and captures imem_data into a small prefetch FIFO. It presents {pc, instr} to the decode stage over a valid/ready handshake. It also handles control-flow redirects and raises misaligned or out-of-range fetch faults.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
IMEM_BYTES, 1000001, byte count of the imem array (addresses 0..IMEM_BYTES-1).
FIFO_DEPTH, 2, prefetch entries; power of two, >=2.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
imem_addr  output  32  byte address to imem; equals fetch_pc.
imem_data  input  32  combinational instruction word from imem for imem_addr.
redirect_valid  input  1  single-cycle pulse: flush and restart fetch at redirect_pc.
redirect_pc  input  32  new fetch address, sampled when redirect_valid=1.
out_valid  output  1  FIFO head valid.
out_ready  input  1  consumer accepts head when out_valid&&out_ready.
out_pc  output  32  PC of head entry.
out_instr  output  32  instruction word of head entry.
out_fault  output  1  head entry is a fetch fault.

Behaviour:
- Reset (async, immediate): fetch_pc=RESET_PC; FIFO empty; state=RUN; out_valid=0, out_pc=0, out_instr=0, out_fault=0.
- out_* are driven from the FIFO head. When empty, out_pc, out_instr and out_fault are 0. No combinational path from imem_data to out_*.
- pop = out_valid && out_ready && !out_fault.
- The fault head never pops; out_ready is ignored while out_fault=1.
- issue_ok = (state==RUN) && (count<FIFO_DEPTH || pop).
- fetch_ok = fetch_pc[1:0]==0 && fetch_pc <= IMEM_BYTES-4. Compare in 33 bits; no wrap.
- RUN, issue_ok, fetch_ok:
  - Enqueue {fetch_pc, imem_data, fault=0} at the edge.
  - fetch_pc += 4, modulo 2^32.
- RUN, issue_ok, !fetch_ok:
  - Enqueue {fetch_pc, 32'h0, fault=1}.
  - fetch_pc holds; state -> FAULT.
- FAULT: no issue; imem_addr holds the faulting pc. Earlier good entries still drain normally, then the fault entry sits at the head, sticky.
- Redirect (highest priority), at the edge with redirect_valid=1, from any state:
  - FIFO flushed; fetch_pc=redirect_pc; state=RUN.
  - A pop in the same cycle counts as a completed handshake, but its entry is discarded with the flush.
  - No enqueue that cycle.
  - out_valid=0 the following cycle. The first post-redirect entry is visible 2 cycles after the redirect edge.
- Simultaneous pop and issue with a full FIFO: count unchanged, entries shift in order.
- Throughput: 1 instr/cycle when out_ready is held high.
- Latency:
  - After reset release, the first edge enqueues RESET_PC; out_valid=1 after that edge.
  - Enqueue-to-visible is 0 cycles when the FIFO is empty.
- Count ranges 0..FIFO_DEPTH and never overflows. Pointers wrap mod FIFO_DEPTH.
- Redirect to a misaligned or out-of-range pc: the next issue produces a fault entry with out_pc=redirect_pc.
- Reset asserted mid-stream: immediate clear; any in-flight entries are lost; no X on outputs.

Test Plan:
- Reset release, imem words W0..W3 at 0,4,8,12, out_ready=1 → out_pc 0,4,8,12 on consecutive cycles, out_instr=W0..W3, out_fault=0.
- Hold out_ready=0 for 5 cycles → count saturates at 2, fetch_pc=8, imem_addr=8. Release → entries pc 0,4 then 8 with no loss or duplication.
- Redirect to 0x100 while the FIFO is full and out_ready=1 → next cycle out_valid=0, then out_pc=0x100, 0x104. Old entries are never presented after the redirect.
- Redirect to 0x102 → out_valid=1, out_fault=1, out_pc=0x102, out_instr=0. The entry stays with out_ready=1 for 10 cycles. A later redirect to 0x0 recovers.
- Sequential fetch up to 999996 with IMEM_BYTES=1000001:
  - 999996 is delivered normally.
  - Next entry is out_pc=1000000 with out_fault=1.
  - imem_addr holds 1000000.
- Assert rst mid-stream with 2 entries queued → outputs are 0 immediately without waiting for clk. After release, fetch restarts at RESET_PC.
